rle_encoder: RTL and testbench
==============================

Name: rle_encoder

Overview:
Run-length encoder that compresses a raster pixel stream into (value, count) pairs. It sits directly upstream of the RLE decoder and produces the data_out/count_out/valid_out pair stream that the decoder consumes. Input and output use valid/ready handshakes with a single-entry output register, so back-pressure stalls the pixel source losslessly.

Parameters:
DATA_W, 8, pixel and pair-value width
COUNT_W, 8, run-count width
MAX_RUN, 255, longest run per pair; must satisfy 1 <= MAX_RUN <= 2^COUNT_W-1
PAIRS_W, 16, width of the emitted-pair counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
pixel_in  in  DATA_W  input pixel
pixel_valid  in  1  pixel_in valid
pixel_last  in  1  marks final pixel of frame; qualified by the pixel handshake
pixel_ready  out  1  encoder accepts pixel this cycle
data_out  out  DATA_W  pair value
count_out  out  COUNT_W  pair run length, always 1..MAX_RUN
valid_out  out  1  pair valid; held until out_ready
out_ready  in  1  downstream accepts pair
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of frame
pair_count  out  PAIRS_W  pairs emitted this frame

Behaviour:
- Reset: state=IDLE; data_out=0, count_out=0, valid_out=0, done=0, pair_count=0; internal run_val=0, run_cnt=0. Reset mid-frame drops the open run and any unaccepted pair.
- Output register: slot_free = !valid_out || out_ready. A pair written into the register sets valid_out on the next edge. The pair is held stable while valid_out && !out_ready. Drain and load can occur in the same cycle. On drain with no load, valid_out clears.
- pixel_ready = (state==ACCUM) && slot_free. This is combinational from out_ready. A pixel is accepted when pixel_valid && pixel_ready.
- States:
  - IDLE:
    - done=0.
    - On start: run_cnt<=0, pair_count<=0, go to ACCUM.
    - pixel_valid is ignored.
  - ACCUM, on an accepted pixel p:
    - run_cnt==0: run_val<=p, run_cnt<=1.
    - p==run_val && run_cnt<MAX_RUN: run_cnt<=run_cnt+1.
    - Otherwise (value change, or run_cnt==MAX_RUN): load (run_val, run_cnt) into the output register; pair_count++; run_val<=p, run_cnt<=1.
    - If pixel_last is set: go to FLUSH after the update above.
  - FLUSH:
    - When slot_free: load (run_val, run_cnt) into the output register; pair_count++; run_cnt<=0; go to DONE.
    - Otherwise wait in FLUSH.
  - DONE: done<=1 for one cycle, then IDLE. valid_out may still be pending; it drains normally in IDLE.
- Latency: a pair appears on valid_out 1 cycle after the accepting edge of the pixel that terminates it, or 1 cycle after the FLUSH load.
- Wrap-around: pair_count wraps modulo 2^PAIRS_W. Run counts never wrap, because MAX_RUN forces a split.
- start outside IDLE is ignored. pixel_last in a non-accepted cycle is ignored.
- A frame whose first pixel carries pixel_last emits exactly one pair with count 1.
- No zero-count pair is ever emitted.

Test Plan:
- Start, then pixels 5,5,5,9,9 (last on the final 9), out_ready=1 -> pairs (5,3),(9,2) in order; done pulses once; pair_count=2.
- 300 consecutive pixels of 0x7F with last -> (0x7F,255),(0x7F,45); count_out never exceeds 255.
- Back-pressure: out_ready=0, pixels 1,2,3 offered -> (1,1) is held on the outputs and pixel_ready drops once the next break needs the slot. Raise out_ready -> (1,1),(2,1),(3,1) are delivered with no loss or duplication.
- Single pixel 0xAA with pixel_last -> exactly one pair (0xAA,1), then done; busy returns to 0.
- Alternating 1,2,1,2 with last, out_ready toggling every cycle -> four pairs each with count 1, and every pair is held stable while out_ready=0.
- Assert rst after 3 pixels of a run -> all outputs are 0 immediately and no pair is emitted. A new start with pixels 4,4 plus last -> (4,2) only, pair_count=1.

Source files
------------

// File: rtl/rle_encoder.sv
// rle_encoder: run-length encoder. It turns a raster pixel stream into
// (value, count) pairs. A single-entry output register sits between the
// encoder and downstream, so back-pressure stalls the pixel source without
// losing data.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin a frame (sampled only in IDLE)
//   pixel_in/valid/last/ready   pixel input handshake; last marks end of frame
//   data_out/count_out/valid_out, out_ready   pair output handshake
//   busy               encoder is inside a frame (state != IDLE)
//   done               one-cycle pulse after the final pair is loaded
//   pair_count         pairs emitted in the current/last frame (wraps)
//
// State | meaning
//   IDLE  | waiting for start; pixels ignored
//   ACCUM | accepting pixels and extending/closing runs
//   FLUSH | loading the final open run once the output slot frees
//   DONE  | frame complete; raises done on the way back to IDLE
module rle_encoder #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8,
    parameter int MAX_RUN = 255,
    parameter int PAIRS_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  pixel_in,
    input  logic               pixel_valid,
    input  logic               pixel_last,
    output logic               pixel_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic [COUNT_W-1:0] count_out,
    output logic               valid_out,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [PAIRS_W-1:0] pair_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_RUN_C = COUNT_W'(MAX_RUN);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  run_val_q, run_val_d;
    logic [COUNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [PAIRS_W-1:0] pair_count_q, pair_count_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic slot_free;
    logic accept;
    logic load;

    // The slot is usable when empty or being drained this very cycle.
    assign slot_free   = !valid_q || out_ready;
    assign pixel_ready = (state_q == S_ACCUM) && slot_free;
    assign accept      = pixel_valid && pixel_ready;

    always_comb begin
        state_d      = state_q;
        run_val_d    = run_val_q;
        run_cnt_d    = run_cnt_q;
        pair_count_d = pair_count_q;
        load         = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    run_cnt_d    = '0;
                    pair_count_d = '0;
                    state_d      = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (run_cnt_q == '0) begin
                        run_val_d = pixel_in;
                        run_cnt_d = COUNT_W'(1);
                    end else if (pixel_in == run_val_q && run_cnt_q < MAX_RUN_C) begin
                        run_cnt_d = run_cnt_q + COUNT_W'(1);
                    end else begin
                        // Value change or full run: close the current run.
                        load         = 1'b1;
                        pair_count_d = pair_count_q + PAIRS_W'(1);
                        run_val_d    = pixel_in;
                        run_cnt_d    = COUNT_W'(1);
                    end
                    if (pixel_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    load         = 1'b1;
                    pair_count_d = pair_count_q + PAIRS_W'(1);
                    run_cnt_d    = '0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: a load always closes the current run_val/run_cnt.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = run_val_q;
            count_d = run_cnt_q;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            run_val_q    <= '0;
            run_cnt_q    <= '0;
            pair_count_q <= '0;
            data_q       <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_val_q    <= run_val_d;
            run_cnt_q    <= run_cnt_d;
            pair_count_q <= pair_count_d;
            data_q       <= data_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    assign data_out   = data_q;
    assign count_out  = count_q;
    assign valid_out  = valid_q;
    assign done       = done_q;
    assign pair_count = pair_count_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rle_encoder.sv
module tb_rle_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_last;
    logic        pixel_ready;
    logic [7:0]  data_out;
    logic [7:0]  count_out;
    logic        valid_out;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] pair_count;

    rle_encoder #(.DATA_W(8), .COUNT_W(8), .MAX_RUN(255), .PAIRS_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_last(pixel_last),
        .pixel_ready(pixel_ready),
        .data_out(data_out), .count_out(count_out), .valid_out(valid_out),
        .out_ready(out_ready), .busy(busy), .done(done), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int done_base;
    int rdy_mode = 0;            // 0: always ready, 1: never ready, 2: toggle
    logic [15:0] exp_q[$];       // {data, count}

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // Monitor: checks transfers against the scoreboard and hold stability.
    logic        held = 1'b0;
    logic [15:0] held_pair;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (held) begin
                    chk("hold_valid", int'(valid_out), 1);
                    chk("hold_pair", int'({data_out, count_out}), int'(held_pair));
                end
                if (valid_out && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pair", int'({data_out, count_out}), -1);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        chk("pair_data", int'(data_out), int'(e[15:8]));
                        chk("pair_count", int'(count_out), int'(e[7:0]));
                    end
                    total_cnt++;
                    if (count_out >= 8'd1 && count_out <= 8'd255) pass_cnt++;
                    else $display("FAIL count_range: got %0d expected 1..255", count_out);
                end
                held      = valid_out && !out_ready;
                held_pair = {data_out, count_out};
            end
        end
    end

    task automatic start_frame();
        done_base = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (pixel_ready) break;
            n++;
            if (n > 2000) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, input logic last);
        pixel_in    = p;
        pixel_valid = 1'b1;
        pixel_last  = last;
        wait_accept();
    endtask

    task automatic end_frame(input int exp_pairs);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy && !valid_out && exp_q.size() == 0) break;
            n++;
            if (n > 2000) begin
                chk("frame_timeout", 0, 1);
                break;
            end
        end
        repeat (2) @(negedge clk);
        chk("pair_count_out", int'(pair_count), exp_pairs);
        chk("done_pulses", done_cnt - done_base, 1);
        chk("busy_idle", int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pixel_in = '0; pixel_valid = 1'b0; pixel_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data_out), 0);
        chk("rst_count", int'(count_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pairs", int'(pair_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(pixel_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic runs
        start_frame();
        exp_q.push_back({8'd5, 8'd3});
        exp_q.push_back({8'd9, 8'd2});
        send(8'd5, 0); send(8'd5, 0); send(8'd5, 0); send(8'd9, 0); send(8'd9, 1);
        end_frame(2);

        // Long run split at 255
        start_frame();
        exp_q.push_back({8'h7F, 8'd255});
        exp_q.push_back({8'h7F, 8'd45});
        for (int i = 0; i < 300; i++) send(8'h7F, (i == 299));
        end_frame(2);

        // Back-pressure
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        start_frame();
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd1});
        exp_q.push_back({8'd3, 8'd1});
        send(8'd1, 0);
        send(8'd2, 0);
        pixel_in = 8'd3; pixel_valid = 1'b1; pixel_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_ready_low", int'(pixel_ready), 0);
        chk("bp_valid", int'(valid_out), 1);
        chk("bp_data", int'(data_out), 1);
        chk("bp_cnt", int'(count_out), 1);
        rdy_mode = 0;
        wait_accept();
        end_frame(3);

        // Single pixel frame
        start_frame();
        exp_q.push_back({8'hAA, 8'd1});
        send(8'hAA, 1);
        end_frame(1);

        // Alternating values with toggling out_ready
        rdy_mode = 2;
        start_frame();
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd1});
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd1});
        send(8'd1, 0); send(8'd2, 0); send(8'd1, 0); send(8'd2, 1);
        end_frame(4);
        rdy_mode = 0;

        // Reset mid-frame drops the run
        start_frame();
        send(8'd6, 0); send(8'd6, 0); send(8'd6, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", int'(data_out), 0);
        chk("mid_rst_count", int'(count_out), 0);
        chk("mid_rst_valid", int'(valid_out), 0);
        chk("mid_rst_pairs", int'(pair_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_frame();
        exp_q.push_back({8'd4, 8'd2});
        send(8'd4, 0); send(8'd4, 1);
        end_frame(1);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
